fetch_unit: RTL and testbench

// - IF stage of the 5-stage MIPS pipeline: owns the PC, fetches from instruction memory, loads IF/ID.
// - Producer of the instruction stream that the ID-stage control decoder consumes; honours hazard-unit stalls, MEM-stage branch redirects.
// - Instruction memory may take >=0 extra cycles; request/ready handshake decouples latency.

---
 rtl/fetch_unit_pkg.sv | 21 ++
 rtl/fetch_unit_ifid_reg.sv | 32 +++
 rtl/fetch_unit.sv | 157 +++++++++++++++
 tb/tb_fetch_unit.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the IF stage: fetch state codes, the NOP encoding
// used for IF/ID bubbles, and a small helper on the state encoding.
package fetch_unit_pkg;

  localparam int INSTR_W = 32;

  // sll $0,$0,0 -- the all-zero word doubles as the bubble instruction
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic [1:0] {
    IF_FETCH = 2'b00,  // request outstanding at PC
    IF_HOLD  = 2'b01,  // fetched word parked while the pipe is stalled
    IF_DRAIN = 2'b10   // wrong-path request still in flight, data discarded
  } if_state_t;

  // Only the HOLD state refrains from talking to instruction memory
  function automatic logic is_requesting(input if_state_t s);
    return (s != IF_HOLD);
  endfunction

endpackage

// File: rtl/fetch_unit_ifid_reg.sv
// IF/ID pipeline register. A flush forces a bubble (valid=0, NOP) and wins
// over a load; with neither, the register holds its contents.
module ifid_reg
  import fetch_unit_pkg::*;
#(
  parameter int PC_W = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               we,
  input  logic               flush,
  input  logic [INSTR_W-1:0] d_instr,
  input  logic [PC_W-1:0]    d_pc_plus4,
  output logic [INSTR_W-1:0] instr,
  output logic [PC_W-1:0]    pc_plus4,
  output logic               valid
);

  // IF/ID boundary: bubble on reset or flush, otherwise load when enabled
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      instr    <= NOP_INSTR;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (we) begin
      instr    <= d_instr;
      pc_plus4 <= d_pc_plus4;
      valid    <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// IF stage of the 5-stage MIPS pipeline: owns the PC, issues requests to
// instruction memory through a req/ready handshake, parks a fetched word
// while the hazard unit stalls, and drains a wrong-path request after a
// MEM-stage branch redirect.
// Optional build macro FETCH_PERF_EN adds perf_fetched / perf_bubbles
// counters of valid and bubble IF/ID loads.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ready,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               stall,
  input  logic               pcsrc,
  input  logic [PC_W-1:0]    branch_target,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [PC_W-1:0]    ifid_pc_plus4,
  output logic               ifid_valid
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_bubbles
`endif
);

  if_state_t          state;
  logic [PC_W-1:0]    pc;
  logic [PC_W-1:0]    pc_plus4;
  logic [PC_W-1:0]    redirect_pc;
  logic [PC_W-1:0]    target_aligned;
  logic [INSTR_W-1:0] hold_buf;

  logic               ifid_we;
  logic               ifid_flush;
  logic [INSTR_W-1:0] ifid_d_instr;

  function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] a);
    return a & ~PC_W'(3);
  endfunction

  // PC arithmetic wraps naturally at 2^PC_W
  assign pc_plus4       = pc + PC_W'(4);
  assign target_aligned = word_align(branch_target);

  // In DRAIN the PC register still holds the wrong-path address, so the
  // outstanding request keeps a stable address until memory answers.
  assign imem_req  = !reset && is_requesting(state);
  assign imem_addr = pc;

  // Decide what the IF/ID register does this cycle
  always_comb begin
    ifid_we      = 1'b0;
    ifid_flush   = 1'b0;
    ifid_d_instr = imem_rdata;
    unique case (state)
      IF_FETCH: begin
        if (pcsrc || (!stall && !imem_ready)) begin
          ifid_flush = 1'b1;
        end else if (!stall && imem_ready) begin
          ifid_we = 1'b1;
        end
      end
      IF_HOLD: begin
        if (pcsrc) begin
          ifid_flush = 1'b1;
        end else if (!stall) begin
          ifid_we      = 1'b1;
          ifid_d_instr = hold_buf;
        end
      end
      IF_DRAIN: ifid_flush = 1'b1;
      default:  ifid_flush = 1'b1;
    endcase
  end

  // Fetch state machine, PC, hold buffer and redirect latch
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IF_FETCH;
      pc    <= RESET_PC;
    end else begin
      unique case (state)
        IF_FETCH: begin
          if (pcsrc) begin
            if (imem_ready) begin
              pc <= target_aligned;
            end else begin
              redirect_pc <= target_aligned;
              state       <= IF_DRAIN;
            end
          end else if (imem_ready) begin
            if (stall) begin
              hold_buf <= imem_rdata;
              state    <= IF_HOLD;
            end else begin
              pc <= pc_plus4;
            end
          end
        end
        IF_HOLD: begin
          if (pcsrc) begin
            pc       <= target_aligned;
            hold_buf <= NOP_INSTR;
            state    <= IF_FETCH;
          end else if (!stall) begin
            pc    <= pc_plus4;
            state <= IF_FETCH;
          end
        end
        IF_DRAIN: begin
          if (pcsrc) begin
            redirect_pc <= target_aligned;
          end else if (imem_ready) begin
            pc    <= redirect_pc;
            state <= IF_FETCH;
          end
        end
        default: state <= IF_FETCH;
      endcase
    end
  end

  ifid_reg #(
    .PC_W(PC_W)
  ) u_ifid (
    .clock      (clock),
    .reset      (reset),
    .we         (ifid_we),
    .flush      (ifid_flush),
    .d_instr    (ifid_d_instr),
    .d_pc_plus4 (pc_plus4),
    .instr      (ifid_instr),
    .pc_plus4   (ifid_pc_plus4),
    .valid      (ifid_valid)
  );

`ifdef FETCH_PERF_EN
  // Count IF/ID loads: real instructions versus bubbles
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else if (ifid_flush) begin
      perf_bubbles <= perf_bubbles + 32'd1;
    end else if (ifid_we) begin
      perf_fetched <= perf_fetched + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with hand-derived
// expectations plus a randomized run against a behavioural model of the
// fetch rules (PC, parked word, pending redirect).
module tb_fetch_unit;

  localparam int          PC_W     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        pcsrc = 1'b0;
  logic [31:0] branch_target = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc_plus4;
  logic        ifid_valid;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_bubbles;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clock = ~clock;

  fetch_unit #(.PC_W(PC_W), .RESET_PC(RESET_PC)) dut (
    .clock         (clock),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .ifid_instr    (ifid_instr),
    .ifid_pc_plus4 (ifid_pc_plus4),
    .ifid_valid    (ifid_valid)
`ifdef FETCH_PERF_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_bubbles  (perf_bubbles)
`endif
  );

  // Behavioural model: the PC being fetched, an optional parked word waiting
  // out a stall, and an optional pending redirect while a stale request drains.
  logic [31:0] m_pc, m_park_word, m_redirect, m_instr, m_pc4;
  logic [31:0] m_fetched, m_bubbles;
  bit          m_parked, m_draining, m_valid;

  always @(posedge clock) begin
    if (reset) begin
      m_pc = RESET_PC; m_parked = 0; m_draining = 0;
      m_instr = 0; m_pc4 = 0; m_valid = 0; m_fetched = 0; m_bubbles = 0;
    end else if (m_draining) begin
      m_valid = 0; m_instr = 0; m_bubbles = m_bubbles + 1;
      if (pcsrc) m_redirect = branch_target & ~32'h3;
      else if (imem_ready) begin m_pc = m_redirect; m_draining = 0; end
    end else if (pcsrc) begin
      m_valid = 0; m_instr = 0; m_bubbles = m_bubbles + 1;
      if (!m_parked && !imem_ready) begin
        m_draining = 1; m_redirect = branch_target & ~32'h3;
      end else begin
        m_pc = branch_target & ~32'h3;
      end
      m_parked = 0;
    end else if (m_parked) begin
      if (!stall) begin
        m_instr = m_park_word; m_pc4 = m_pc + 4; m_valid = 1;
        m_pc = m_pc + 4; m_parked = 0; m_fetched = m_fetched + 1;
      end
    end else if (imem_ready) begin
      if (stall) begin
        m_parked = 1; m_park_word = imem_rdata;
      end else begin
        m_instr = imem_rdata; m_pc4 = m_pc + 4; m_valid = 1;
        m_pc = m_pc + 4; m_fetched = m_fetched + 1;
      end
    end else if (!stall) begin
      m_valid = 0; m_instr = 0; m_bubbles = m_bubbles + 1;
    end
  end

  // Drive one cycle's inputs just after the falling edge
  task automatic set_in(input logic rdy, input logic [31:0] rd, input logic st,
                        input logic ps, input logic [31:0] tgt);
    @(negedge clock);
    reset = 1'b0; imem_ready = rdy; imem_rdata = rd; stall = st;
    pcsrc = ps; branch_target = tgt;
    #1;
  endtask

  task automatic next_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; imem_ready = 1'b0; stall = 1'b0; pcsrc = 1'b0;
    @(posedge clock);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clock);
    reset = 1'b1; imem_ready = 1'b1; imem_rdata = 32'hDEAD_BEEF; stall = 1'b0; pcsrc = 1'b0;
    #1;
    n_checks++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %b want 0", imem_req); else n_pass++;
    next_edge();
    n_checks++; if (ifid_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", ifid_valid); else n_pass++;
    n_checks++; if (ifid_instr !== 32'h0) $display("FAIL reset_instr: got %h want 0", ifid_instr); else n_pass++;
    n_checks++; if (ifid_pc_plus4 !== 32'h0) $display("FAIL reset_pc4: got %h want 0", ifid_pc_plus4); else n_pass++;
`ifdef FETCH_PERF_EN
    n_checks++; if (perf_fetched !== 0 || perf_bubbles !== 0) $display("FAIL reset_perf: got %0d/%0d want 0/0", perf_fetched, perf_bubbles); else n_pass++;
`endif
    set_in(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) $display("FAIL reset_first_req: got %b/%h want 1/%h", imem_req, imem_addr, RESET_PC); else n_pass++;
    next_edge();
    n_checks++; if (ifid_valid !== 1'b0) $display("FAIL reset_nordy_bubble: got %b want 0", ifid_valid); else n_pass++;
  endtask

  task automatic test_stream();
    logic [31:0] w;
    do_reset();
    for (int k = 0; k < 3; k++) begin
      w = $urandom;
      set_in(1'b1, w, 1'b0, 1'b0, 32'h0);
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'(4 * k)) $display("FAIL stream_addr%0d: got %b/%h want 1/%h", k, imem_req, imem_addr, 4 * k); else n_pass++;
      next_edge();
      n_checks++; if (ifid_valid !== 1'b1 || ifid_pc_plus4 !== 32'(4 * k + 4) || ifid_instr !== w) $display("FAIL stream_ifid%0d: got %b/%h/%h want 1/%h/%h", k, ifid_valid, ifid_pc_plus4, ifid_instr, 4 * k + 4, w); else n_pass++;
    end
  endtask

  task automatic test_wait_states();
    logic [31:0] w;
    do_reset();
    set_in(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    next_edge();
    for (int k = 0; k < 2; k++) begin
      set_in(1'b0, $urandom, 1'b0, 1'b0, 32'h0);
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) $display("FAIL wait_addr%0d: got %b/%h want 1/00000004", k, imem_req, imem_addr); else n_pass++;
      next_edge();
      n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) $display("FAIL wait_bubble%0d: got %b/%h want 0/00000000", k, ifid_valid, ifid_instr); else n_pass++;
    end
    w = $urandom;
    set_in(1'b1, w, 1'b0, 1'b0, 32'h0);
    n_checks++; if (imem_addr !== 32'h4) $display("FAIL wait_addr_final: got %h want 00000004", imem_addr); else n_pass++;
    next_edge();
    n_checks++; if (ifid_valid !== 1'b1 || ifid_instr !== w || ifid_pc_plus4 !== 32'h8) $display("FAIL wait_load: got %b/%h/%h want 1/%h/00000008", ifid_valid, ifid_instr, ifid_pc_plus4, w); else n_pass++;
  endtask

  task automatic test_stall_hold();
    logic [31:0] w0, w1;
    w0 = $urandom; w1 = $urandom;
    do_reset();
    set_in(1'b1, w0, 1'b0, 1'b0, 32'h0);
    next_edge();
    set_in(1'b1, w1, 1'b1, 1'b0, 32'h0);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h4) $display("FAIL hold_req: got %b/%h want 1/00000004", imem_req, imem_addr); else n_pass++;
    next_edge();
    n_checks++; if (ifid_instr !== w0 || ifid_pc_plus4 !== 32'h4 || ifid_valid !== 1'b1) $display("FAIL hold_frozen0: got %h/%h want %h/00000004", ifid_instr, ifid_pc_plus4, w0); else n_pass++;
    for (int k = 0; k < 2; k++) begin
      set_in(1'($urandom_range(0, 1)), $urandom, 1'b1, 1'b0, 32'h0);
      n_checks++; if (imem_req !== 1'b0) $display("FAIL hold_noreq%0d: got %b want 0", k, imem_req); else n_pass++;
      next_edge();
      n_checks++; if (ifid_instr !== w0 || ifid_valid !== 1'b1) $display("FAIL hold_frozen%0d: got %h want %h", k + 1, ifid_instr, w0); else n_pass++;
    end
    set_in(1'b0, $urandom, 1'b0, 1'b0, 32'h0);
    next_edge();
    n_checks++; if (ifid_instr !== w1 || ifid_pc_plus4 !== 32'h8 || ifid_valid !== 1'b1) $display("FAIL hold_release: got %b/%h/%h want 1/%h/00000008", ifid_valid, ifid_instr, ifid_pc_plus4, w1); else n_pass++;
    set_in(1'b0, $urandom, 1'b0, 1'b0, 32'h0);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8) $display("FAIL hold_next_addr: got %b/%h want 1/00000008", imem_req, imem_addr); else n_pass++;
    next_edge();
  endtask

  task automatic test_redirect_drain();
    logic [31:0] w;
    do_reset();
    set_in(1'b0, $urandom, 1'b0, 1'b1, 32'h103);
    next_edge();
    n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) $display("FAIL drain_flush: got %b/%h want 0/00000000", ifid_valid, ifid_instr); else n_pass++;
    for (int k = 0; k < 3; k++) begin
      set_in(1'(k == 2), $urandom, 1'(k == 0), 1'b0, 32'h0);
      n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) $display("FAIL drain_addr%0d: got %b/%h want 1/00000000", k, imem_req, imem_addr); else n_pass++;
      next_edge();
      n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) $display("FAIL drain_bubble%0d: got %b/%h want 0/00000000", k, ifid_valid, ifid_instr); else n_pass++;
    end
    w = $urandom;
    set_in(1'b1, w, 1'b0, 1'b0, 32'h0);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) $display("FAIL drain_target: got %b/%h want 1/00000100", imem_req, imem_addr); else n_pass++;
    next_edge();
    n_checks++; if (ifid_valid !== 1'b1 || ifid_instr !== w || ifid_pc_plus4 !== 32'h104) $display("FAIL drain_resume: got %b/%h/%h want 1/%h/00000104", ifid_valid, ifid_instr, ifid_pc_plus4, w); else n_pass++;
  endtask

  task automatic test_flush_beats_stall();
    do_reset();
    set_in(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    next_edge();
    set_in(1'b1, $urandom, 1'b1, 1'b1, 32'h2000);
    next_edge();
    n_checks++; if (ifid_valid !== 1'b0 || ifid_instr !== 32'h0) $display("FAIL flush_stall_bubble: got %b/%h want 0/00000000", ifid_valid, ifid_instr); else n_pass++;
    set_in(1'b0, $urandom, 1'b0, 1'b0, 32'h0);
    n_checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h2000) $display("FAIL flush_stall_addr: got %b/%h want 1/00002000", imem_req, imem_addr); else n_pass++;
    next_edge();
  endtask

  task automatic test_wrap();
    do_reset();
    set_in(1'b1, $urandom, 1'b0, 1'b1, 32'hFFFF_FFFF);
    next_edge();
    set_in(1'b1, $urandom, 1'b0, 1'b0, 32'h0);
    n_checks++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr: got %h want fffffffc", imem_addr); else n_pass++;
    next_edge();
    n_checks++; if (ifid_valid !== 1'b1 || ifid_pc_plus4 !== 32'h0) $display("FAIL wrap_pc4: got %b/%h want 1/00000000", ifid_valid, ifid_pc_plus4); else n_pass++;
`ifdef FETCH_PERF_EN
    n_checks++; if (perf_fetched !== 32'd1 || perf_bubbles !== 32'd1) $display("FAIL wrap_perf: got %0d/%0d want 1/1", perf_fetched, perf_bubbles); else n_pass++;
`endif
    set_in(1'b0, $urandom, 1'b0, 1'b0, 32'h0);
    n_checks++; if (imem_addr !== 32'h0) $display("FAIL wrap_next: got %h want 00000000", imem_addr); else n_pass++;
    next_edge();
  endtask

  task automatic test_random();
    int errs;
    bit exp_req;
    errs = 0;
    do_reset();
    for (int i = 0; i < 3000 && errs < 10; i++) begin
      @(negedge clock);
      reset = ($urandom_range(0, 299) == 0);
      imem_ready = ($urandom_range(0, 99) < 60);
      stall = ($urandom_range(0, 99) < 25);
      pcsrc = ($urandom_range(0, 99) < 8);
      imem_rdata = $urandom;
      branch_target = $urandom;
      #1;
      exp_req = !reset && (m_draining || !m_parked);
      n_checks++; if (imem_req !== exp_req) begin errs++; $display("FAIL rand_req@%0d: got %b want %b", i, imem_req, exp_req); end else n_pass++;
      if (exp_req) begin
        n_checks++; if (imem_addr !== m_pc) begin errs++; $display("FAIL rand_addr@%0d: got %h want %h", i, imem_addr, m_pc); end else n_pass++;
      end
      next_edge();
      n_checks++;
      if (ifid_valid !== m_valid || ifid_instr !== m_instr || (m_valid && ifid_pc_plus4 !== m_pc4)) begin
        errs++;
        $display("FAIL rand_ifid@%0d: got %b/%h/%h want %b/%h/%h", i, ifid_valid, ifid_instr, ifid_pc_plus4, m_valid, m_instr, m_pc4);
      end else n_pass++;
`ifdef FETCH_PERF_EN
      n_checks++; if (perf_fetched !== m_fetched || perf_bubbles !== m_bubbles) begin errs++; $display("FAIL rand_perf@%0d: got %0d/%0d want %0d/%0d", i, perf_fetched, perf_bubbles, m_fetched, m_bubbles); end else n_pass++;
`endif
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_stream();
    test_wait_states();
    test_stall_hold();
    test_redirect_drain();
    test_flush_beats_stall();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
